// File: rtl/hex_ascii_serializer_pkg.sv
// Shared constants and state encoding for the hex-dump serializer.
package hex_ascii_serializer_pkg;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] HEX_DIGIT_BASE = 8'h30;
  localparam logic [7:0] HEX_LOWER_BASE = 8'h61;
  localparam logic [7:0] HEX_UPPER_BASE = 8'h41;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEX  = 3'd1;
  localparam logic [2:0] ST_SEP  = 3'd2;
  localparam logic [2:0] ST_CR   = 3'd3;
  localparam logic [2:0] ST_LF   = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    HEX  = ST_HEX,
    SEP  = ST_SEP,
    CR   = ST_CR,
    LF   = ST_LF
  } state_e;
endpackage

// File: rtl/hex_ascii_serializer_digit.sv
// Combinational nibble -> ASCII hex digit mapping.
module hex_digit_ascii
  import hex_ascii_serializer_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) ascii = HEX_DIGIT_BASE + {4'h0, nibble};
    else ascii = (UPPERCASE ? HEX_UPPER_BASE : HEX_LOWER_BASE) + {4'h0, nibble} - 8'd10;
  end
endmodule

// File: rtl/hex_ascii_serializer.sv
// Streams WIDTH-bit words as ASCII hex, MSB nibble first, with separators
// between words and CR/LF every LINE_WORDS words or on a flush request.
module hex_ascii_serializer
  import hex_ascii_serializer_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter bit         UPPERCASE  = 1'b0,
  parameter bit         SEP_EN     = 1'b1,
  parameter logic [7:0] SEPARATOR  = 8'h20,
  parameter int         LINE_WORDS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    nib_cnt, nib_cnt_d;
  logic [7:0]       word_cnt, word_cnt_d;
  logic             flush_q, flush_pend, flush_d;
  logic [7:0]       digit, char_d;

  // A flush pulse counts as pending in the cycle it arrives, so IDLE can
  // react immediately and a coincident word is held off.
  assign flush_pend = flush_q || flush;
  assign in_ready   = (state == IDLE) && !flush_pend && !reset;
  assign busy       = (state != IDLE) || flush_pend;

  hex_digit_ascii #(.UPPERCASE(UPPERCASE)) u_digit (
    .nibble(shreg_d[WIDTH-1 -: 4]),
    .ascii (digit)
  );

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    nib_cnt_d  = nib_cnt;
    word_cnt_d = word_cnt;
    flush_d    = flush_pend;
    case (state)
      IDLE: begin
        if (flush_pend) begin
          if (word_cnt != 8'd0) state_d = CR;
          else flush_d = 1'b0;
        end else if (in_valid) begin
          shreg_d    = in_data;
          nib_cnt_d  = CW'(NIBBLES - 1);
          state_d    = HEX;
          word_cnt_d = (word_cnt == 8'(LINE_WORDS)) ? word_cnt : word_cnt + 8'd1;
        end
      end
      HEX: if (out_ready) begin
        shreg_d   = shreg << 4;
        nib_cnt_d = nib_cnt - CW'(1);
        if (nib_cnt == '0) begin
          if (word_cnt == 8'(LINE_WORDS)) state_d = CR;
          else if (SEP_EN)                state_d = SEP;
          else                            state_d = IDLE;
        end
      end
      SEP: if (out_ready) state_d = IDLE;
      CR:  if (out_ready) state_d = LF;
      LF: if (out_ready) begin
        state_d    = IDLE;
        word_cnt_d = 8'd0;
        flush_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output character is precomputed from the next state so out_char/out_valid
  // come straight from flops; a stall leaves state and shreg unchanged.
  always_comb begin
    char_d = out_char;
    case (state_d)
      HEX:     char_d = digit;
      SEP:     char_d = SEPARATOR;
      CR:      char_d = ASCII_CR;
      LF:      char_d = ASCII_LF;
      default: char_d = out_char;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      nib_cnt   <= '0;
      word_cnt  <= 8'd0;
      flush_q   <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      nib_cnt   <= nib_cnt_d;
      word_cnt  <= word_cnt_d;
      flush_q   <= flush_d;
      out_valid <= (state_d != IDLE);
      if (state_d != IDLE) out_char <= char_d;
    end
  end
endmodule
